// File: rtl/rv32_types.sv
// rv32_types: shared zicsr op encoding, CSR address type and machine-mode CSR address map.
package rv32_types;
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } zicsr_op_t;
  typedef logic [11:0] csr_addr_t;
  localparam csr_addr_t CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t CSR_ADDR_MSCRATCH      = 12'h340;
  localparam csr_addr_t CSR_ADDR_MCYCLE        = 12'hB00;
  localparam csr_addr_t CSR_ADDR_MINSTRET      = 12'hB02;
  localparam csr_addr_t CSR_ADDR_MHPMCOUNTER3  = 12'hB03;
  localparam csr_addr_t CSR_ADDR_MCYCLEH       = 12'hB80;
  localparam csr_addr_t CSR_ADDR_MINSTRETH     = 12'hB82;
  localparam csr_addr_t CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
  localparam csr_addr_t CSR_ADDR_CYCLE         = 12'hC00;
  localparam csr_addr_t CSR_ADDR_INSTRET       = 12'hC02;
  localparam csr_addr_t CSR_ADDR_HPMCOUNTER3   = 12'hC03;
  localparam csr_addr_t CSR_ADDR_CYCLEH        = 12'hC80;
  localparam csr_addr_t CSR_ADDR_INSTRETH      = 12'hC82;
  localparam csr_addr_t CSR_ADDR_HPMCOUNTER3H  = 12'hC83;
  // Writable mcountinhibit bits: CY, IR and one per implemented HPM counter.
  function automatic logic [31:0] inhibit_mask(int num_hpm);
    return 32'h5 | (((32'd1 << num_hpm) - 32'd1) << 3);
  endfunction
endpackage

// File: rtl/rv32_csr_counter64.sv
// rv32_csr_counter64: one 64-bit event counter with per-half writes; a write beats the increment.
module rv32_csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0] cur, nxt;
  always_comb begin
    cur = 64'(cnt_q);
    nxt = wr_lo_i ? {cur[63:32], wdata_i} : wr_hi_i ? {wdata_i, cur[31:0]} : cur + 64'(inc_i && !inhibit_i);
    cnt_d = WIDTH'(nxt);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign value_o = 64'(cnt_q);
endmodule

// File: rtl/rv32_csr_file.sv
// rv32_csr_file: M-mode CSR storage and zicsr read-modify-write engine for exec.
// Define RV32_CSR_MCOUNTINHIBIT_EN to implement mcountinhibit at 0x320.
module rv32_csr_file
  import rv32_types::*;
#(
  parameter int NUM_HPM   = 4,
  parameter int HPM_WIDTH = 64,
  localparam int HW       = NUM_HPM > 0 ? NUM_HPM : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  input  csr_addr_t     req_addr,
  input  zicsr_op_t     req_op,
  input  logic [31:0]   req_operand,
  input  logic          req_wr_suppress,
  input  logic          instr_retired,
  input  logic [HW-1:0] hpm_event,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_illegal
);
  localparam int NC = NUM_HPM + 2;
  logic [63:0] cnt [32];
  logic [HW+1:0] inc_v;
  logic [31:0] mscratch_q, mscratch_d, old, wdata, mcinh_rd, resp_rdata_q;
  logic [4:0] n, ci;
  logic is_cnt, is_mscr, is_inh, wr_att, illegal, we, cnt_we, resp_valid_q, resp_illegal_q;
  assign inc_v = {hpm_event, instr_retired, 1'b1};
`ifdef RV32_CSR_MCOUNTINHIBIT_EN
  logic [31:0] mcinh_q;
  assign is_inh = req_addr == CSR_ADDR_MCOUNTINHIBIT;
  assign mcinh_rd = mcinh_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) mcinh_q <= '0;
    else if (we && is_inh) mcinh_q <= wdata & inhibit_mask(NUM_HPM);
`else
  assign is_inh = 1'b0;
  assign mcinh_rd = '0;
`endif
  // Counter slot 0 = cycle, 1 = instret, 2+k = HPM k; counter number n maps to slot n-1 above 2.
  always_comb begin
    n = req_addr[4:0];
    ci = n == 5'd0 ? 5'd0 : n == 5'd2 ? 5'd1 : n - 5'd1;
    is_cnt = (req_addr[11:8] == 4'hB || req_addr[11:8] == 4'hC) && req_addr[6:5] == 2'b00 &&
             n != 5'd1 && int'(n) < NUM_HPM + 3;
    is_mscr = req_addr == CSR_ADDR_MSCRATCH;
    wr_att = req_op == CSR_RW || ((req_op == CSR_RS || req_op == CSR_RC) && !req_wr_suppress);
    illegal = !(is_cnt || is_mscr || is_inh) || (req_addr[11:10] == 2'b11 && wr_att);
    old = is_mscr ? mscratch_q : is_inh ? mcinh_rd :
          is_cnt ? (req_addr[7] ? cnt[ci][63:32] : cnt[ci][31:0]) : '0;
    wdata = req_op == CSR_RW ? req_operand : req_op == CSR_RS ? (old | req_operand) : (old & ~req_operand);
    we = req_valid && !illegal && wr_att;
    cnt_we = we && is_cnt;
    mscratch_d = (we && is_mscr) ? wdata : mscratch_q;
  end
  for (genvar g = 0; g < 32; g++) begin : g_cnt
    if (g < NC) begin : g_on
      rv32_csr_counter64 #(.WIDTH(g < 2 ? 64 : HPM_WIDTH)) u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .inc_i     (inc_v[g]),
`ifdef RV32_CSR_MCOUNTINHIBIT_EN
        .inhibit_i (mcinh_q[g == 0 ? 0 : g + 1]),
`else
        .inhibit_i (1'b0),
`endif
        .wr_lo_i   (cnt_we && ci == 5'(g) && !req_addr[7]),
        .wr_hi_i   (cnt_we && ci == 5'(g) && req_addr[7]),
        .wdata_i   (wdata),
        .value_o   (cnt[g])
      );
    end else begin : g_off
      assign cnt[g] = '0;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_rdata_q <= '0;
      mscratch_q <= '0;
    end else begin
      resp_valid_q <= req_valid;
      resp_illegal_q <= req_valid && illegal;
      resp_rdata_q <= (req_valid && !illegal) ? old : '0;
      mscratch_q <= mscratch_d;
    end
  assign resp_valid = resp_valid_q;
  assign resp_illegal = resp_illegal_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_rv32_csr_file.sv
// tb_rv32_csr_file: directed plus randomized zicsr traffic against an arithmetic CSR model.
module tb_rv32_csr_file;
  import rv32_types::*;
  localparam int NUM = 2;
  localparam logic [31:0] INH_MASK = 32'h1D;
  logic clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, req_wr_suppress = 1'b0, instr_retired = 1'b0;
  logic [11:0] req_addr = '0;
  zicsr_op_t req_op = CSR_NONE;
  logic [31:0] req_operand = '0;
  logic [NUM-1:0] hpm_event = '0;
  logic resp_valid, resp_illegal;
  logic [31:0] resp_rdata, last_rd;
  int checks = 0, fails = 0;
  logic [63:0] m_c [4];
  logic [31:0] m_scr, m_inh;
  bit inh_en;

  rv32_csr_file #(.NUM_HPM(NUM), .HPM_WIDTH(64)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
    .req_operand(req_operand), .req_wr_suppress(req_wr_suppress), .instr_retired(instr_retired),
    .hpm_event(hpm_event), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_c[k] = '0;
    m_scr = '0;
    m_inh = '0;
  endtask

  function automatic int cidx(logic [11:0] a);
    logic [11:0] base = a & ~12'h080;
    if (base == 12'hB00 || base == 12'hC00) return 0;
    if (base == 12'hB02 || base == 12'hC02) return 1;
    for (int k = 0; k < NUM; k++)
      if (base == 12'hB03 + 12'(k) || base == 12'hC03 + 12'(k)) return k + 2;
    return -1;
  endfunction

  function automatic bit mimpl(logic [11:0] a);
    return a == 12'h340 || (inh_en && a == 12'h320) || cidx(a) >= 0;
  endfunction

  function automatic logic [31:0] mread(logic [11:0] a);
    int c = cidx(a);
    if (a == 12'h340) return m_scr;
    if (a == 12'h320) return m_inh;
    if (c < 0) return '0;
    return a[7] ? m_c[c][63:32] : m_c[c][31:0];
  endfunction

  task automatic step(input bit v, input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                      input bit sup, input bit ret, input logic [1:0] ev);
    bit wa, legal, e_il, inc;
    logic [31:0] old, nv, e_rd;
    logic [63:0] nx [4];
    int c;
    @(negedge clk);
    req_valid = v; req_addr = a; req_op = zicsr_op_t'(op); req_operand = d;
    req_wr_suppress = sup; instr_retired = ret; hpm_event = ev;
    wa = op == 2'd1 || (op >= 2'd2 && !sup);
    legal = mimpl(a) && !(a[11:10] == 2'b11 && wa);
    old = legal ? mread(a) : '0;
    nv = op == 2'd1 ? d : op == 2'd2 ? (old | d) : (old & ~d);
    e_rd = (v && legal) ? old : '0;
    e_il = v && !legal;
    c = cidx(a);
    for (int k = 0; k < 4; k++) begin
      inc = k == 0 ? 1'b1 : k == 1 ? ret : ev[k-2];
      nx[k] = m_c[k] + ((inc && !m_inh[k == 0 ? 0 : k + 1]) ? 64'd1 : 64'd0);
    end
    @(posedge clk);
    if (v && legal && wa) begin
      if (a == 12'h340) m_scr = nv;
      else if (a == 12'h320) m_inh = nv & INH_MASK;
      else nx[c] = a[7] ? {nv, m_c[c][31:0]} : {m_c[c][63:32], nv};
    end
    for (int k = 0; k < 4; k++) m_c[k] = nx[k];
    #1;
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, v});
    chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, e_il});
    chk($sformatf("resp_rdata@%h", a), resp_rdata, e_rd);
    last_rd = resp_rdata;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 12'h000, 2'd0, 32'd0, 0, 0, 2'b00);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1, a, 2'd2, 32'd0, 1, 0, 2'b00);
  endtask

  initial begin
    logic [11:0] pool [21];
    pool = '{12'h340, 12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84,
             12'hB05, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC84, 12'hC05, 12'h7FF, 12'hF11, 12'hB01};
`ifdef RV32_CSR_MCOUNTINHIBIT_EN
    inh_en = 1'b1;
`else
    inh_en = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_illegal", {31'd0, resp_illegal}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    #1 resetn = 1'b1;

    idle(10);
    rd(12'hC00);
    chk("cycle_after_10", last_rd, 32'd10);

    step(1, 12'h340, 2'd1, 32'hDEADBEEF, 0, 0, 2'b00);
    chk("mscratch_rw_old", last_rd, 32'd0);
    step(1, 12'h340, 2'd2, 32'h0000000F, 0, 0, 2'b00);
    chk("mscratch_rs_old", last_rd, 32'hDEADBEEF);
    step(1, 12'h340, 2'd3, 32'hF0000000, 0, 0, 2'b00);
    chk("mscratch_rc_old", last_rd, 32'hDEADBEEF);
    rd(12'h340);
    chk("mscratch_final", last_rd, 32'h0EADBEEF);

    step(1, 12'hB00, 2'd1, 32'hFFFFFFFF, 0, 0, 2'b00);
    step(1, 12'hB80, 2'd1, 32'h00000000, 0, 0, 2'b00);
    idle(2);
    rd(12'hB80);
    chk("mcycleh_carry", last_rd, 32'd1);
    rd(12'hB00);

    step(1, 12'hC00, 2'd1, 32'h12345678, 0, 0, 2'b00);
    chk("ro_write_illegal", {31'd0, resp_illegal}, 32'd1);
    step(1, 12'h7FF, 2'd1, 32'h1, 0, 0, 2'b00);
    chk("unimpl_illegal", {31'd0, resp_illegal}, 32'd1);
    rd(12'hC00);

    for (int i = 0; i < 5; i++) step(0, 12'h000, 2'd0, 32'd0, 0, 0, 2'b10);
    rd(12'hB04);
    chk("hpm4_five", last_rd, 32'd5);
    rd(12'hB05);
    chk("hpm5_illegal", {31'd0, resp_illegal}, 32'd1);

    step(1, 12'h320, 2'd1, 32'h1, 0, 0, 2'b00);
    idle(20);
    rd(12'hB00);
    step(1, 12'h320, 2'd1, 32'h0, 0, 0, 2'b00);

    step(1, 12'hB02, 2'd1, 32'h7, 0, 1, 2'b00);
    step(1, 12'hB02, 2'd2, 32'd0, 1, 1, 2'b00);
    chk("instret_write_wins", last_rd, 32'd7);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 4) != 0, pool[$urandom_range(0, 20)], 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'hC00; req_op = CSR_RS; req_wr_suppress = 1'b1;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #2 resetn = 1'b1;
    rd(12'hC00);
    chk("cycle_after_rst", last_rd, 32'd0);
    rd(12'h340);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
